// File: rtl/logicnet_readout_pkg.sv
// Shared widths, types and logit unpacking for the LogicNets argmax readout.
package logicnet_readout_pkg;

  localparam int N_CLASS = 5;
  localparam int LOGIT_W = 3;
  localparam int IDX_W   = 3;
  localparam int VEC_W   = N_CLASS * LOGIT_W;
  localparam int EQ_W    = $clog2(N_CLASS + 1);

  typedef logic [LOGIT_W-1:0] logit_t;
  typedef logic [IDX_W-1:0]   class_idx_t;
  typedef logic [VEC_W-1:0]   vec_t;
  typedef logic [EQ_W-1:0]    eq_cnt_t;

  typedef struct packed {
    class_idx_t cls;
    logit_t     max;
    logic       tie;
  } decision_t;

  function automatic logit_t unpack_logit(vec_t vec, int unsigned k);
    return vec[k*LOGIT_W +: LOGIT_W];
  endfunction

endpackage

// File: rtl/logicnet_argmax_tree.sv
// Combinational argmax over the packed logits: lowest index wins a tie, plus a tie flag.
module logicnet_argmax_tree
  import logicnet_readout_pkg::*;
(
  input  vec_t      vec_i,
  output decision_t dec_o
);

  logit_t     best;
  class_idx_t best_idx;
  eq_cnt_t    n_eq;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    best     = unpack_logit(vec_i, 0);
    best_idx = '0;
    n_eq     = '0;
    // Strict greater-than keeps the earliest index among equal maxima.
    for (int k = 1; k < N_CLASS; k++) begin
      if (unpack_logit(vec_i, k) > best) begin
        best     = unpack_logit(vec_i, k);
        best_idx = class_idx_t'(k);
      end
    end
    for (int k = 0; k < N_CLASS; k++) begin
      if (unpack_logit(vec_i, k) == best) n_eq = n_eq + eq_cnt_t'(1);
    end
    dec_o = '{cls: best_idx, max: best, tie: (n_eq >= eq_cnt_t'(2))};
  end

endmodule

// File: rtl/logicnet_argmax_readout.sv
// Two-stage valid/ready pipeline: S1 holds the M1 vector, S2 holds the argmax decision.
module logicnet_argmax_readout
  import logicnet_readout_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VEC_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_class,
  output logic [LOGIT_W-1:0] out_max,
  output logic               out_tie,
  output logic [CNT_W-1:0]   result_count
);

  logic       s1_valid_q, s1_valid_d;
  vec_t       s1_data_q,  s1_data_d;
  logic       s2_valid_q, s2_valid_d;
  decision_t  dec_q,      dec_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       s1_take, s2_take;
  decision_t  tree_dec;

  logicnet_argmax_tree u_tree (
    .vec_i (s1_data_q),
    .dec_o (tree_dec)
  );

  // in_ready depends combinationally on out_ready so a full pipe can still stream.
  assign s2_take  = !s2_valid_q || out_ready;
  assign s1_take  = !s1_valid_q || s2_take;
  assign in_ready = s1_take;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    dec_d      = dec_q;
    count_d    = count_q;
    if (s1_take) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_data_d = in_data;
    end
    if (s2_take) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) dec_d = tree_dec;
    end
    if (s2_valid_q && out_ready) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      // NOTE: the data registers are cleared too; valid bits alone would suffice, but
      // defined contents keep out_* at zero after reset and stop X reaching the tree.
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      dec_q      <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      dec_q      <= dec_d;
      count_q    <= count_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_class    = dec_q.cls;
  assign out_max      = dec_q.max;
  assign out_tie      = dec_q.tie;
  assign result_count = count_q;

endmodule

// File: tb/tb_logicnet_argmax_readout.sv
// Directed and randomised checks of the argmax readout pipeline against a bench-side model.
module tb_logicnet_argmax_readout;
  import logicnet_readout_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [14:0] in_data = '0;
  logic        in_ready, out_valid, out_tie;
  logic [2:0]  out_class, out_max;
  logic [15:0] result_count;
  logic        w4_in_ready, w4_out_valid, w4_out_tie;
  logic [2:0]  w4_out_class, w4_out_max;
  logic [3:0]  w4_result_count;

  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  logic [6:0] sb_q[$];
  logic [6:0] mon_exp, mon_got;

  logicnet_argmax_readout #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_max(out_max),
    .out_tie(out_tie), .result_count(result_count)
  );

  logicnet_argmax_readout #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w4_in_ready), .in_data(in_data),
    .out_valid(w4_out_valid), .out_ready(out_ready), .out_class(w4_out_class),
    .out_max(w4_out_max), .out_tie(w4_out_tie), .result_count(w4_result_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: find the max value first, then the first index holding it and how many do.
  function automatic logic [6:0] ref_argmax(input logic [14:0] v);
    logic [2:0] lg[5];
    logic [2:0] mx;
    int first;
    int n;
    mx = 3'd0;
    first = -1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      lg[k] = v[3*k +: 3];
      if (lg[k] > mx) mx = lg[k];
    end
    for (int k = 0; k < 5; k++) begin
      if (lg[k] == mx) begin
        n++;
        if (first < 0) first = k;
      end
    end
    return {3'(first), mx, (n >= 2)};
  endfunction

  function automatic logic [14:0] pack5(input int l0, l1, l2, l3, l4);
    return {3'(l4), 3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  // Scoreboard: pop on output transfer, then push on input transfer of the same cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got class=%0d max=%0d, expected no decision", out_class, out_max);
        end else begin
          mon_exp = sb_q.pop_front();
          mon_got = {out_class, out_max, out_tie};
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL sb_decision: got {class,max,tie}=%b, expected %b", mon_got, mon_exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_argmax(in_data));
        n_in++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    n_in = 0;
    n_out = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (result_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", result_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    checks++;
    if ({out_class, out_max, out_tie} !== 7'd0) begin
      errors++;
      $display("FAIL reset_fields: got class=%0d max=%0d tie=%b, expected all 0", out_class, out_max, out_tie);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1;
    in_data = 15'b000_111_010_011_001;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency1: out_valid got %b, expected 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_class, out_max, out_tie} !== {1'b1, 3'd3, 3'd7, 1'b0}) begin
      errors++;
      $display("FAIL single_decision: got valid=%b class=%0d max=%0d tie=%b, expected 1 3 7 0",
               out_valid, out_class, out_max, out_tie);
    end
    @(posedge clk); #1;
    checks++;
    if (result_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d, expected 1", result_count); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: out_valid got %b, expected 0", out_valid); end
  endtask

  task automatic test_tie();
    logic [14:0] vecs[4];
    logic [7:0]  exps[4];
    vecs[0] = pack5(5, 2, 5, 5, 1); exps[0] = {1'b1, 3'd0, 3'd5, 1'b1};
    vecs[1] = pack5(0, 0, 0, 0, 0); exps[1] = {1'b1, 3'd0, 3'd0, 1'b1};
    vecs[2] = pack5(4, 6, 6, 3, 6); exps[2] = {1'b1, 3'd1, 3'd6, 1'b1};
    vecs[3] = pack5(0, 0, 0, 0, 7); exps[3] = {1'b1, 3'd4, 3'd7, 1'b0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = vecs[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_class, out_max, out_tie} !== exps[i]) begin
        errors++;
        $display("FAIL tie_vec%0d: got {valid,class,max,tie}=%b, expected %b", i,
                 {out_valid, out_class, out_max, out_tie}, exps[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [14:0] v[4];
    int i;
    int cyc;
    v[0] = pack5(7, 0, 0, 0, 0);
    v[1] = pack5(1, 6, 2, 2, 0);
    v[2] = pack5(0, 0, 5, 1, 1);
    v[3] = pack5(2, 3, 1, 4, 4);
    do_reset();
    i = 0;
    for (cyc = 0; cyc < 40 && !(i == 4 && n_out == 4); cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      out_ready = (cyc >= 6);
      in_valid = (i < 4);
      in_data = v[i < 4 ? i : 3];
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || i != 2) begin
          errors++;
          $display("FAIL bp_in_ready_drop: got in_ready=%b after %0d accepts, expected 0 after 2", in_ready, i);
        end
      end
      if (cyc == 4) begin
        checks++;
        if ({in_ready, out_valid, out_class, out_max} !== {1'b0, 1'b1, 3'd0, 3'd7}) begin
          errors++;
          $display("FAIL bp_hold: got in_ready=%b valid=%b class=%0d max=%0d, expected 0 1 0 7",
                   in_ready, out_valid, out_class, out_max);
        end
      end
      if (in_valid && in_ready) i++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n_out != 4 || cyc >= 40) begin errors++; $display("FAIL bp_delivered: got %0d decisions, expected 4", n_out); end
    checks++;
    if (result_count !== 16'd4) begin errors++; $display("FAIL bp_count: got %0d, expected 4", result_count); end
  endtask

  task automatic test_stream();
    int not_ready;
    not_ready = 0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      in_valid = 1'b1;
      in_data = 15'($urandom);
      @(negedge clk);
      if (in_ready !== 1'b1) not_ready++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (not_ready != 0) begin errors++; $display("FAIL stream_in_ready: %0d stalled cycles, expected 0", not_ready); end
    checks++;
    if (n_out != 1000) begin errors++; $display("FAIL stream_delivered: got %0d, expected 1000", n_out); end
    checks++;
    if (result_count !== 16'd1000) begin errors++; $display("FAIL stream_count: got %0d, expected 1000", result_count); end
  endtask

  task automatic test_random();
    int stall_bad;
    logic prev_stall;
    logic [6:0] prev_fields;
    stall_bad = 0;
    prev_stall = 1'b0;
    prev_fields = '0;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      in_valid = 1'($urandom % 2);
      out_ready = (($urandom % 4) != 0);
      in_data = in_valid ? 15'($urandom) : 15'($urandom_range(0, 7));
      @(negedge clk);
      if (prev_stall && (!out_valid || {out_class, out_max, out_tie} !== prev_fields)) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_fields = {out_class, out_max, out_tie};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL random_stall_hold: %0d changes during stall, expected 0", stall_bad); end
    checks++;
    if (n_in != n_out || sb_q.size() != 0) begin
      errors++;
      $display("FAIL random_conservation: in=%0d out=%0d pending=%0d, expected equal and 0 pending", n_in, n_out, sb_q.size());
    end
    checks++;
    if (result_count !== 16'(n_out)) begin errors++; $display("FAIL random_count: got %0d, expected %0d", result_count, n_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data = 15'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (w4_result_count !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %0d, expected 1", w4_result_count); end
    checks++;
    if (result_count !== 16'd17) begin errors++; $display("FAIL wrap_cnt16: got %0d, expected 17", result_count); end
  endtask

  task automatic test_reset_mid();
    int leaked;
    leaked = 0;
    do_reset();
    in_valid = 1'b1;
    in_data = pack5(0, 0, 0, 0, 6);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      errors++;
      $display("FAIL mid_full: got in_ready=%b out_valid=%b, expected 0 1", in_ready, out_valid);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    checks++;
    if ({out_valid, result_count} !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset: got out_valid=%b count=%0d, expected 0 0", out_valid, result_count);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked++;
    end
    checks++;
    if (leaked != 0) begin errors++; $display("FAIL mid_leak: %0d cycles with stale output, expected 0", leaked); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_stream();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
